pwm_duty_decoder: RTL
=====================

// Module: pwm_duty_decoder
// PURPOSE
//  Receive-side counterpart of the RGB PWM generator. Samples an incoming PWM line on the shared
//  clock_enable tick and measures high time and period for each PWM frame. Decodes the 2-bit duty
//  code (0 / 12.5 / 25 / 50 %) the generator was driven with, and flags malformed or stuck signals.
//  Used for loopback self-check of the RGB channels and to read PWM from external sources.
// PARAMETERS
//  RESOLUTION  4  PWM counter width; nominal period = 2**RESOLUTION ticks; must be >= 3
// PORTS
//  clock         in   1             system clock, single clock domain
//  reset         in   1             synchronous, active-low: reset==0 at posedge clears all state
//  clock_enable  in   1             sample tick, same strobe that drives the generator's counter
//  pwm_in        in   1             PWM line, asynchronous to clock
//  duty_cnt      out  RESOLUTION+1  high-tick count of the last published frame
//  sw_code       out  2             decoded duty: 00=0, 01=DT_12_5, 10=DT_25, 11=DT_50
//  valid         out  1             one-clock pulse when duty_cnt/sw_code/mismatch update
//  mismatch      out  1             last frame: period != 2**RESOLUTION, or high count not a legal duty
//  stuck_high    out  1             sticky; set by a high run of >= 2**RESOLUTION ticks, cleared on next valid
// BEHAVIOUR
//  Reset values: all outputs 0; FSM=SEEK; counters 0; synchronizer flops 0; prev_level 0.
//  pwm_in passes through a 2-flop synchronizer clocked every clock. The synchronized level is
//   sampled only on clock_enable. prev_level updates only on ticks.
//  rise = tick & lvl & ~prev_level; fall = tick & ~lvl & prev_level. Nothing advances without a tick.
//  PERIOD = 2**RESOLUTION. hi_cnt and lo_cnt are RESOLUTION+1 bits and saturate at all-ones.
//  FSM states:
//   SEEK: wait for rise. On rise: hi_cnt<=1, lo_cnt<=0, go HIGH.
//   HIGH: each high tick hi_cnt++. On fall: lo_cnt<=1, go LOW.
//   LOW:  each low tick lo_cnt++. On rise: PUBLISH this frame, then hi_cnt<=1, lo_cnt<=0, stay framing (go HIGH).
//  PUBLISH (registered, valid=1 on the clock after the rise tick):
//   duty_cnt<=hi_cnt.
//   sw_code: hi_cnt==DT_12_5 -> 01, DT_25 -> 10, DT_50 -> 11, otherwise 00.
//   mismatch<=(hi_cnt+lo_cnt != PERIOD) | hi_cnt not in {DT_12_5, DT_25, DT_50}.
//   stuck_high<=0.
//  Stuck low: a consecutive low run reaches PERIOD ticks in any state. Action: publish duty_cnt=0,
//   sw_code=00, mismatch=0, valid pulse; go SEEK; restart the run. Repeats every PERIOD ticks while low.
//  Stuck high: a consecutive high run reaches PERIOD ticks. Action: stuck_high<=1, no valid, go SEEK.
//   The first frame after SEEK is never published; it only re-synchronizes the FSM.
//  Reset mid-frame: partial counts are discarded. Outputs remain 0 until the first complete frame after reset.
//  rise and stuck-low on the same tick: the rise wins.
//  valid is never asserted for two consecutive clocks.
// STRUCTURE
//  pwm_pkg (shared with the generator):
//   localparams DT_50/DT_25/DT_12_5 as functions of RESOLUTION.
//   typedef enum logic [1:0] {SEEK, HIGH, LOW} pwm_dec_state_t.
//   typedef logic [1:0] pwm_sw_t.
//  Sub-module pwm_edge_sync: 2-flop synchronizer, tick-gated prev_level, rise/fall outputs.
//  The top level holds the FSM, the saturating counters and the output registers.
// TESTING (RESOLUTION=4, PERIOD=16; pwm_in driven by the generator, clock_enable every 4th clock)
//  1 Generator SW=11 -> from the 2nd rise on, valid every 16 ticks: duty_cnt=8, sw_code=11, mismatch=0.
//  2 Sweep SW 01/10 -> duty_cnt=2/4, sw_code=01/10. After an SW change, one frame of the new value
//    appears within 2 frames; there is no spurious valid.
//  3 SW=00 (line held low) -> valid every 16 ticks, duty_cnt=0, sw_code=00, stuck_high=0.
//  4 Force pwm_in=1 for 20 ticks -> stuck_high=1 at tick 16 with no valid. Then SW=11 -> stuck_high=0
//    with the first valid.
//  5 Bench-driven frame high 3 / low 13 -> duty_cnt=3, sw_code=00, mismatch=1.
//    Then high 8 / low 10 -> mismatch=1 (period 18).
//  6 reset=0 for 1 clock mid-HIGH -> all outputs 0 next clock. No valid until one full frame
//    after the first rise post-reset. Toggling pwm_in with clock_enable=0 -> no state change.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared PWM definitions: duty thresholds, decoder states and switch codes.
// Used by both the RGB PWM generator and the receive-side duty decoder.
package pwm_pkg;

    localparam int PWM_RESOLUTION = 4;

    function automatic int dt_50(input int res);
        return 1 << (res - 1);
    endfunction

    function automatic int dt_25(input int res);
        return 1 << (res - 2);
    endfunction

    function automatic int dt_12_5(input int res);
        return 1 << (res - 3);
    endfunction

    localparam int DT_50   = dt_50(PWM_RESOLUTION);
    localparam int DT_25   = dt_25(PWM_RESOLUTION);
    localparam int DT_12_5 = dt_12_5(PWM_RESOLUTION);

    typedef enum logic [1:0] {
        SEEK,
        HIGH,
        LOW
    } pwm_dec_state_t;

    typedef logic [1:0] pwm_sw_t;

    localparam pwm_sw_t SW_0    = 2'b00;
    localparam pwm_sw_t SW_12_5 = 2'b01;
    localparam pwm_sw_t SW_25   = 2'b10;
    localparam pwm_sw_t SW_50   = 2'b11;

endpackage

// File: rtl/pwm_edge_sync.sv
// Two-flop synchronizer for the PWM line plus tick-gated edge detection.
// rise/fall only ever assert on a clock_enable tick.
module pwm_edge_sync (
    input  logic clock,
    input  logic reset,
    input  logic clock_enable,
    input  logic pwm_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sync_q1;
    logic sync_q2;
    logic prev_level;

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_q1    <= 1'b0;
            sync_q2    <= 1'b0;
            prev_level <= 1'b0;
        end else begin
            sync_q1 <= pwm_in;
            sync_q2 <= sync_q1;
            if (clock_enable) begin
                prev_level <= sync_q2;
            end
        end
    end

    assign level = sync_q2;
    assign rise  = clock_enable & sync_q2 & ~prev_level;
    assign fall  = clock_enable & ~sync_q2 & prev_level;

endmodule

// File: rtl/pwm_duty_decoder.sv
// Measures high time and period of each PWM frame, decodes the duty code
// and flags malformed frames and stuck-high / stuck-low lines.
module pwm_duty_decoder
    import pwm_pkg::*;
#(
    parameter int RESOLUTION = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clock_enable,
    input  logic                  pwm_in,
    output logic [RESOLUTION:0]   duty_cnt,
    output pwm_sw_t               sw_code,
    output logic                  valid,
    output logic                  mismatch,
    output logic                  stuck_high
);

    localparam int CW = RESOLUTION + 1;

    localparam logic [CW-1:0] PERIOD = CW'(1 << RESOLUTION);
    localparam logic [CW-1:0] ONE    = CW'(1);
    localparam logic [CW-1:0] D50    = CW'(dt_50(RESOLUTION));
    localparam logic [CW-1:0] D25    = CW'(dt_25(RESOLUTION));
    localparam logic [CW-1:0] D12    = CW'(dt_12_5(RESOLUTION));

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + ONE;
    endfunction

    logic level;
    logic rise;
    logic fall;

    pwm_edge_sync u_edge_sync (
        .clock        (clock),
        .reset        (reset),
        .clock_enable (clock_enable),
        .pwm_in       (pwm_in),
        .level        (level),
        .rise         (rise),
        .fall         (fall)
    );

    pwm_dec_state_t state;
    pwm_dec_state_t state_n;
    logic [CW-1:0]  hi_cnt;
    logic [CW-1:0]  hi_n;
    logic [CW-1:0]  lo_cnt;
    logic [CW-1:0]  lo_n;
    logic [CW-1:0]  run_cnt;
    logic [CW-1:0]  run_n;
    logic           pub_frame;
    logic           pub_low;
    logic           set_stuck;
    pwm_sw_t        sw_n;
    logic           legal;
    logic [CW:0]    frame_len;
    logic           mismatch_n;

    always_comb begin
        state_n   = state;
        hi_n      = hi_cnt;
        lo_n      = lo_cnt;
        run_n     = run_cnt;
        pub_frame = 1'b0;
        pub_low   = 1'b0;
        set_stuck = 1'b0;
        if (clock_enable) begin
            run_n = (rise | fall) ? ONE : sat_inc(run_cnt);
            unique case (state)
                SEEK: begin
                    if (rise) begin
                        hi_n    = ONE;
                        lo_n    = '0;
                        state_n = HIGH;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        lo_n    = ONE;
                        state_n = LOW;
                    end else begin
                        hi_n = sat_inc(hi_cnt);
                    end
                end
                LOW: begin
                    if (rise) begin
                        pub_frame = 1'b1;
                        hi_n      = ONE;
                        lo_n      = '0;
                        state_n   = HIGH;
                    end else begin
                        lo_n = sat_inc(lo_cnt);
                    end
                end
                default: state_n = SEEK;
            endcase
            // Run length hits exactly one period: restart low runs so they repeat.
            if (!level && !rise && run_n == PERIOD) begin
                pub_low = 1'b1;
                state_n = SEEK;
                run_n   = '0;
            end else if (level && run_n == PERIOD) begin
                set_stuck = 1'b1;
                state_n   = SEEK;
            end
        end
    end

    always_comb begin
        sw_n  = SW_0;
        legal = 1'b1;
        unique case (1'b1)
            (hi_cnt == D12): sw_n = SW_12_5;
            (hi_cnt == D25): sw_n = SW_25;
            (hi_cnt == D50): sw_n = SW_50;
            default:         legal = 1'b0;
        endcase
        frame_len  = {1'b0, hi_cnt} + {1'b0, lo_cnt};
        mismatch_n = (frame_len != {1'b0, PERIOD}) | ~legal;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= SEEK;
            hi_cnt     <= '0;
            lo_cnt     <= '0;
            run_cnt    <= '0;
            duty_cnt   <= '0;
            sw_code    <= SW_0;
            valid      <= 1'b0;
            mismatch   <= 1'b0;
            stuck_high <= 1'b0;
        end else begin
            state   <= state_n;
            hi_cnt  <= hi_n;
            lo_cnt  <= lo_n;
            run_cnt <= run_n;
            valid   <= pub_frame | pub_low;
            if (pub_frame) begin
                duty_cnt   <= hi_cnt;
                sw_code    <= sw_n;
                mismatch   <= mismatch_n;
                stuck_high <= 1'b0;
            end else if (pub_low) begin
                duty_cnt   <= '0;
                sw_code    <= SW_0;
                mismatch   <= 1'b0;
                stuck_high <= 1'b0;
            end else if (set_stuck) begin
                stuck_high <= 1'b1;
            end
        end
    end

endmodule
